// File: rtl/clock_disp_pkg.sv
// Shared constants, digit-index type and binary-to-BCD helper for the clock display scanner.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [2:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Returns {tens, ones}; 60..63 are deliberately not clamped and give tens=6.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

endpackage

// File: rtl/clock_disp_scan_if.sv
// Count inputs and display outputs of the scanner; master is the counter/board side.
interface clock_disp_scan_if;
  logic [5:0] count_sec;
  logic [5:0] count_min;
  logic [5:0] count_hrs;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output count_sec, count_min, count_hrs, input an, seg, dp);
  modport slave  (input count_sec, count_min, count_hrs, output an, seg, dp);
endinterface

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; codes above 9 blank the digit.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed HH MM SS scanner with per-frame snapshot of the counts.
// Optional leading-zero blanking of the hours-tens digit: define CLK_DISP_LZB_EN.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 16'd50000,
  parameter int          DIV_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  clock_disp_scan_if.slave  bus
);

  localparam logic [DIV_W-1:0] TC_VAL   = DIV_W'(REFRESH_DIV - 1);
  localparam digit_idx_t       LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] r_presc;
  digit_idx_t       r_idx;
  logic [5:0]       r_snap_sec, r_snap_min, r_snap_hrs;
  logic [5:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_tc;
  logic             w_wrap;
  logic [7:0]       w_bcd_sec, w_bcd_min, w_bcd_hrs;
  logic [3:0]       w_code;
  logic [6:0]       w_seg;
  logic [5:0]       w_an;
  logic             w_dp;

  assign w_tc   = (r_presc == TC_VAL);
  // Indices 6/7 are unreachable but are folded back to 0 on the next TC.
  assign w_wrap = w_tc && (r_idx >= LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_snap_sec <= '0;
      r_snap_min <= '0;
      r_snap_hrs <= '0;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + DIV_W'(1);
      if (w_wrap)    r_idx <= '0;
      else if (w_tc) r_idx <= r_idx + 3'd1;
      // Snapshot only on the 5->0 wrap so one frame never mixes two ticks.
      if (w_tc && r_idx == LAST_IDX) begin
        r_snap_sec <= bus.count_sec;
        r_snap_min <= bus.count_min;
        r_snap_hrs <= bus.count_hrs;
      end
    end
  end

  assign w_bcd_sec = bin2bcd(r_snap_sec);
  assign w_bcd_min = bin2bcd(r_snap_min);
  assign w_bcd_hrs = bin2bcd(r_snap_hrs);

  always_comb begin
    w_code = 4'hF;
    w_an   = 6'b111111;
    case (r_idx)
      3'd0: begin w_code = w_bcd_sec[3:0]; w_an = 6'b111110; end
      3'd1: begin w_code = w_bcd_sec[7:4]; w_an = 6'b111101; end
      3'd2: begin w_code = w_bcd_min[3:0]; w_an = 6'b111011; end
      3'd3: begin w_code = w_bcd_min[7:4]; w_an = 6'b110111; end
      3'd4: begin w_code = w_bcd_hrs[3:0]; w_an = 6'b101111; end
      3'd5: begin w_code = w_bcd_hrs[7:4]; w_an = 6'b011111; end
      default: begin w_code = 4'hF; w_an = 6'b111111; end
    endcase
`ifdef CLK_DISP_LZB_EN
    // Non-BCD code makes the decoder blank the digit; an[5] still strobes.
    if (r_idx == LAST_IDX && w_code == 4'd0) w_code = 4'hF;
`endif
  end

  assign w_dp = !(r_idx == 3'd2 || r_idx == 3'd4);

  seg7_decode u_dec (
    .i_bcd (w_code),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 6'b111111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Scoreboard bench: two scanners (REFRESH_DIV=4 and 1) checked every cycle against a closed-form model.
module tb_clock_disp_scan;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] in_s, in_m, in_h;

  clock_disp_scan_if u_if4 ();
  clock_disp_scan_if u_if1 ();

  assign u_if4.count_sec = in_s;
  assign u_if4.count_min = in_m;
  assign u_if4.count_hrs = in_h;
  assign u_if1.count_sec = in_s;
  assign u_if1.count_min = in_m;
  assign u_if1.count_hrs = in_h;

  clock_disp_scan #(.REFRESH_DIV(4), .DIV_W(16)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if4.slave)
  );

  clock_disp_scan #(.REFRESH_DIV(1), .DIV_W(16)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1.slave)
  );

  localparam logic [6:0] SEGT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [13:0] RST_OUT = {6'b111111, 7'b1111111, 1'b1};

  int n_run  = 0;
  int n_fail = 0;
  int k;
  logic [5:0] sn4_s, sn4_m, sn4_h, sn1_s, sn1_m, sn1_h;
  logic [13:0] q4[$];
  logic [13:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Output after edge k (k=1 is the first edge after reset release), {an,seg,dp}.
  function automatic logic [13:0] model(input int r, input int kk,
                                        input logic [5:0] s, input logic [5:0] m,
                                        input logic [5:0] h);
    int idx, v, d;
    logic [6:0] sg;
    logic [5:0] a;
    idx = ((kk - 1) / r) % 6;
    case (idx)
      0, 1:    v = int'(s);
      2, 3:    v = int'(m);
      default: v = int'(h);
    endcase
    d  = (idx % 2 == 0) ? v % 10 : v / 10;
    sg = (d < 10) ? SEGT[d] : 7'b1111111;
`ifdef CLK_DISP_LZB_EN
    if (idx == 5 && d == 0) sg = 7'b1111111;
`endif
    a = 6'b111111;
    a[idx] = 1'b0;
    return {a, sg, !(idx == 2 || idx == 4)};
  endfunction

  task automatic clr_model();
    k = 0;
    sn4_s = '0; sn4_m = '0; sn4_h = '0;
    sn1_s = '0; sn1_m = '0; sn1_h = '0;
  endtask

  // Called at a negedge with inputs for the coming edge already applied.
  task automatic step();
    logic [13:0] e4, e1;
    k++;
    q4.push_back(model(4, k, sn4_s, sn4_m, sn4_h));
    q1.push_back(model(1, k, sn1_s, sn1_m, sn1_h));
    if (k % 24 == 0) begin sn4_s = in_s; sn4_m = in_m; sn4_h = in_h; end
    if (k % 6 == 0)  begin sn1_s = in_s; sn1_m = in_m; sn1_h = in_h; end
    @(posedge clk);
    #1;
    e4 = q4.pop_front();
    e1 = q1.pop_front();
    chk($sformatf("r4_k%0d", k), {18'd0, u_if4.an, u_if4.seg, u_if4.dp}, {18'd0, e4});
    chk($sformatf("r1_k%0d", k), {18'd0, u_if1.an, u_if1.seg, u_if1.dp}, {18'd0, e1});
    @(negedge clk);
  endtask

  initial begin
    in_s = '0; in_m = '0; in_h = '0;
    clr_model();
    reset = 1'b1;
    #12;
    chk("rst_r4", {18'd0, u_if4.an, u_if4.seg, u_if4.dp}, {18'd0, RST_OUT});
    chk("rst_r1", {18'd0, u_if1.an, u_if1.seg, u_if1.dp}, {18'd0, RST_OUT});
    @(negedge clk);
    reset = 1'b0;
    clr_model();

    repeat (12) step();
    // Mid-frame change: current frame keeps zeros, next frame shows 12:34:59.
    in_s = 6'd59; in_m = 6'd34; in_h = 6'd12;
    repeat (35) step();
    // Applied right before the wrap edge of the R=4 scanner: captured at its new value.
    in_s = 6'd63; in_m = 6'd0; in_h = 6'd7;
    repeat (63) step();

    for (int i = 0; i < 24 && ((k / 4) % 6) != 3; i++) step();
    chk("idx3_reached", 32'((k / 4) % 6), 32'd3);
    reset = 1'b1;
    #1;
    chk("midrst_r4", {18'd0, u_if4.an, u_if4.seg, u_if4.dp}, {18'd0, RST_OUT});
    chk("midrst_r1", {18'd0, u_if1.an, u_if1.seg, u_if1.dp}, {18'd0, RST_OUT});
    @(negedge clk);
    reset = 1'b0;
    clr_model();
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
